// File: rtl/sequence_counter.sv
// Timing-step sequence counter: a 3-state IDLE/RUN/HALTED controller driving a 4-bit
// step count (sc) that feeds the 4-to-16 timing decoder, wrapping from LAST_T to 0.
module sequence_counter #(
    parameter int LAST_T = 15
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       halt,
    input  logic       clr,
    input  logic       ld,
    input  logic [3:0] ld_val,
    output logic [3:0] sc,
    output logic       run,
    output logic       wrap,
    output logic       t_last,
    output logic       ld_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam logic [3:0] LAST_V = 4'(LAST_T);

    state_e     state_q, state_d;
    logic [3:0] sc_q, sc_d;
    logic       run_q, run_d;
    logic       wrap_q, wrap_d;
    logic       ld_err_q, ld_err_d;
    logic       count_en_s;

    // A load is only accepted when it keeps the count inside the decoder's step range.
    function automatic logic ld_in_range(input logic [3:0] v);
        return (v <= LAST_V);
    endfunction

    // Controller next state; halt dominates start, and an unused encoding recovers to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && !halt) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (halt) begin
                    state_d = HALTED;
                end else begin
                    state_d = RUN;
                end
            end
            HALTED: begin
                if (start && !halt) begin
                    state_d = RUN;
                end else begin
                    state_d = HALTED;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Increment only while already in RUN and not leaving it this edge.
    always_comb begin
        count_en_s = (state_q == RUN) && !halt;
    end

    // Count update with priority clr > ld > increment, plus the pulse outputs.
    always_comb begin
        sc_d     = sc_q;
        wrap_d   = 1'b0;
        ld_err_d = 1'b0;
        if (clr) begin
            sc_d = 4'd0;
        end else if (ld) begin
            if (ld_in_range(ld_val)) begin
                sc_d = ld_val;
            end else begin
                sc_d     = sc_q;
                ld_err_d = 1'b1;
            end
        end else if (count_en_s) begin
            // >= rather than == so a corrupted count above LAST_T still returns to 0
            if (sc_q >= LAST_V) begin
                sc_d   = 4'd0;
                wrap_d = 1'b1;
            end else begin
                sc_d = sc_q + 4'd1;
            end
        end else begin
            sc_d = sc_q;
        end
    end

    // run is registered from the next state so it is high exactly while state_q is RUN.
    always_comb begin
        run_d = (state_d == RUN);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sc_q     <= 4'd0;
            run_q    <= 1'b0;
            wrap_q   <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sc_q     <= sc_d;
            run_q    <= run_d;
            wrap_q   <= wrap_d;
            ld_err_q <= ld_err_d;
        end
    end

    assign sc     = sc_q;
    assign run    = run_q;
    assign wrap   = wrap_q;
    assign ld_err = ld_err_q;
    assign t_last = (sc_q == LAST_V);

endmodule

// File: tb/tb_sequence_counter.sv
// Directed bench for sequence_counter: one instance with LAST_T=15 and one with LAST_T=7,
// driven from shared inputs; each phase checks only the instance it targets.
module tb_sequence_counter;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       start = 1'b0, halt = 1'b0, clr = 1'b0, ld = 1'b0;
    logic [3:0] ld_val = 4'd0;
    logic [3:0] sc_a, sc_b;
    logic       run_a, wrap_a, tl_a, lderr_a;
    logic       run_b, wrap_b, tl_b, lderr_b;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       start, halt, clr, ld;
        logic [3:0] ld_val;
        logic [3:0] sc;
        logic       run, wrap, tl, lderr;
    } vec_t;

    vec_t tbl [23];

    sequence_counter #(.LAST_T(15)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(start), .halt(halt), .clr(clr),
        .ld(ld), .ld_val(ld_val), .sc(sc_a), .run(run_a), .wrap(wrap_a),
        .t_last(tl_a), .ld_err(lderr_a)
    );

    sequence_counter #(.LAST_T(7)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start), .halt(halt), .clr(clr),
        .ld(ld), .ld_val(ld_val), .sc(sc_b), .run(run_b), .wrap(wrap_b),
        .t_last(tl_b), .ld_err(lderr_b)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic s, input logic h, input logic c, input logic l, input logic [3:0] v);
        start = s; halt = h; clr = c; ld = l; ld_val = v;
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        #1;
    endtask

    function automatic vec_t mk(input logic s, input logic h, input logic c, input logic l,
                                input logic [3:0] v, input logic [3:0] e_sc, input logic e_run,
                                input logic e_wrap, input logic e_tl, input logic e_le);
        vec_t r;
        r.start = s; r.halt = h; r.clr = c; r.ld = l; r.ld_val = v;
        r.sc = e_sc; r.run = e_run; r.wrap = e_wrap; r.tl = e_tl; r.lderr = e_le;
        return r;
    endfunction

    initial begin
        int wraps;
        //            st    h     clr   ld    val    sc     run   wrap  tl    lderr
        tbl[0]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd10, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd9,  4'd0,  1'b1, 1'b0, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd1,  1'b1, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd5,  4'd5,  1'b1, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd5,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd5,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  4'd5,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd5,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[10] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd5,  1'b1, 1'b0, 1'b0, 1'b0);
        tbl[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd6,  1'b1, 1'b0, 1'b0, 1'b0);
        tbl[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd7,  1'b1, 1'b0, 1'b0, 1'b0);
        tbl[13] = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[14] = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  4'd15, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd15, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[16] = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[17] = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[18] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  1'b1, 1'b0, 1'b0, 1'b0);
        tbl[19] = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[20] = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  1'b1, 1'b0, 1'b0, 1'b0);
        tbl[21] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd1,  1'b1, 1'b0, 1'b0, 1'b0);
        tbl[22] = mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b0);

        // Reset applied before any clock edge must take effect on its own.
        #1 reset_n = 1'b0;
        #2;
        chk("rst_sc", 0, sc_a, 4'd0);
        chk("rst_run", 0, {3'b0, run_a}, 4'd0);
        chk("rst_wrap", 0, {3'b0, wrap_a}, 4'd0);
        chk("rst_lderr", 0, {3'b0, lderr_a}, 4'd0);
        chk("rst_tlast", 0, {3'b0, tl_a}, 4'd0);
        do_reset();

        // LAST_T=15: start, then count a full lap and wrap.
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        cycle();
        chk("a_start_sc", 0, sc_a, 4'd0);
        chk("a_start_run", 0, {3'b0, run_a}, 4'd1);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        for (int i = 1; i <= 16; i++) begin
            cycle();
            chk("a_lap_sc", i, sc_a, 4'(i % 16));
            chk("a_lap_wrap", i, {3'b0, wrap_a}, (i == 16) ? 4'd1 : 4'd0);
            chk("a_lap_tlast", i, {3'b0, tl_a}, (i == 15) ? 4'd1 : 4'd0);
        end

        // Table of control corner cases, continuing from RUN at sc=0.
        for (int i = 0; i < 23; i++) begin
            set_in(tbl[i].start, tbl[i].halt, tbl[i].clr, tbl[i].ld, tbl[i].ld_val);
            cycle();
            chk("tbl_sc", i, sc_a, tbl[i].sc);
            chk("tbl_run", i, {3'b0, run_a}, {3'b0, tbl[i].run});
            chk("tbl_wrap", i, {3'b0, wrap_a}, {3'b0, tbl[i].wrap});
            chk("tbl_tlast", i, {3'b0, tl_a}, {3'b0, tbl[i].tl});
            chk("tbl_lderr", i, {3'b0, lderr_a}, {3'b0, tbl[i].lderr});
        end

        // LAST_T=7: 20 free-running cycles, then load range checks.
        do_reset();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        cycle();
        chk("b_start_sc", 0, sc_b, 4'd0);
        chk("b_start_run", 0, {3'b0, run_b}, 4'd1);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        wraps = 0;
        for (int i = 1; i < 20; i++) begin
            cycle();
            if (wrap_b) wraps++;
            chk("b_free_sc", i, sc_b, 4'(i % 8));
            chk("b_free_wrap", i, {3'b0, wrap_b}, (i == 8 || i == 16) ? 4'd1 : 4'd0);
            chk("b_free_tlast", i, {3'b0, tl_b}, (i % 8 == 7) ? 4'd1 : 4'd0);
        end
        chk("b_wrap_count", 0, 4'(wraps), 4'd2);

        set_in(1'b0, 1'b0, 1'b0, 1'b1, 4'd10);
        cycle();
        chk("b_badld_sc", 0, sc_b, 4'd3);
        chk("b_badld_err", 0, {3'b0, lderr_b}, 4'd1);
        chk("b_badld_run", 0, {3'b0, run_b}, 4'd1);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cycle();
        chk("b_after_sc", 0, sc_b, 4'd4);
        chk("b_after_err", 0, {3'b0, lderr_b}, 4'd0);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
        cycle();
        chk("b_ld3_sc", 0, sc_b, 4'd3);
        chk("b_ld3_err", 0, {3'b0, lderr_b}, 4'd0);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
        cycle();
        chk("b_ld7_sc", 0, sc_b, 4'd7);
        chk("b_ld7_tlast", 0, {3'b0, tl_b}, 4'd1);
        chk("b_ld7_err", 0, {3'b0, lderr_b}, 4'd0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cycle();
        chk("b_wrap_sc", 0, sc_b, 4'd0);
        chk("b_wrap_pulse", 0, {3'b0, wrap_b}, 4'd1);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 4'd8);
        cycle();
        chk("b_ld8_sc", 0, sc_b, 4'd0);
        chk("b_ld8_err", 0, {3'b0, lderr_b}, 4'd1);
        chk("b_ld8_wrap", 0, {3'b0, wrap_b}, 4'd0);

        // Short asynchronous reset pulse mid-count at sc=9.
        do_reset();
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 4'd9);
        cycle();
        chk("ar_pre_sc", 0, sc_a, 4'd9);
        chk("ar_pre_run", 0, {3'b0, run_a}, 4'd1);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_sc", 0, sc_a, 4'd0);
        chk("ar_run", 0, {3'b0, run_a}, 4'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("ar_hold_sc", i, sc_a, 4'd0);
            chk("ar_hold_run", i, {3'b0, run_a}, 4'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sequence_counter.md
SEQUENCE_COUNTER -- requirements
Module: sequence_counter

Interface
REQ-001 Parameter LAST_T, default 15: highest timing step; range 1..15; count wraps from LAST_T to 0.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  level; begin counting from IDLE, or resume from HALTED.
REQ-005 halt  input  1  level; stop counting and hold the current value.
REQ-006 clr  input  1  synchronous clear of the count to 0.
REQ-007 ld  input  1  synchronous load of ld_val into the count.
REQ-008 ld_val  input  4  load value.
REQ-009 sc  output  4  registered count; drives the 4-to-16 timing decoder select input directly.
REQ-010 run  output  1  registered; 1 only in state RUN.
REQ-011 wrap  output  1  registered one-cycle pulse; sc has just wrapped LAST_T->0.
REQ-012 t_last  output  1  combinational, (sc == LAST_T).
REQ-013 ld_err  output  1  registered one-cycle pulse; load rejected as out of range.

Function
REQ-014 The block SHALL implement a 3-state FSM: IDLE, RUN, HALTED.
REQ-015 IDLE: start=1 and halt=0 SHALL go to RUN next edge; otherwise stay.
REQ-016 RUN: halt=1 SHALL go to HALTED next edge; otherwise stay in RUN.
REQ-017 HALTED: start=1 and halt=0 SHALL go to RUN next edge; otherwise stay.
REQ-018 start and halt both 1 SHALL be treated as halt: IDLE stays IDLE, RUN goes to HALTED.
REQ-019 Count update priority SHALL be clr > ld > increment, evaluated every edge in every state.
REQ-020 clr=1 SHALL set sc=0 next edge, leave FSM state unaffected, and suppress wrap.
REQ-021 ld=1 and clr=0 with ld_val <= LAST_T SHALL set sc=ld_val next edge.
REQ-022 ld=1 and clr=0 with ld_val > LAST_T SHALL hold sc and pulse ld_err=1 for exactly one cycle.
REQ-023 With no clr/ld, sc SHALL increment by 1 only on edges where the current state is RUN.
REQ-024 Counting SHALL begin on the edge after entry to RUN: the entry edge does not increment.
REQ-025 Counting SHALL stop on the edge that leaves RUN: that edge does not increment.
REQ-026 In RUN, sc == LAST_T with no clr/ld SHALL give sc=0 next edge and wrap=1 for that one cycle.
REQ-027 A load to 0 and a clear SHALL NOT assert wrap.
REQ-028 In IDLE and HALTED, sc SHALL hold except on clr or ld.
REQ-029 run SHALL equal 1 exactly in the cycles whose registered state is RUN.
REQ-030 Latency SHALL be one clock from any input to sc, run, wrap and ld_err; t_last SHALL follow sc with no clock delay.
REQ-031 sc SHALL never exceed LAST_T.

Reset
REQ-032 reset_n=0 SHALL immediately, without waiting for a clock edge, force: state=IDLE, sc=0, run=0, wrap=0, ld_err=0.
REQ-033 Reset asserted mid-count SHALL abort the count; after release the block SHALL stay in IDLE until start.
REQ-034 Reset release SHALL be synchronous to clock, so the first active edge follows release.

Verification
REQ-035 Reset, then start pulse, LAST_T=15 -> run=1; sc counts 0,1,...,15,0; wrap=1 only in the cycle sc=0 after 15; t_last=1 only when sc=15.
REQ-036 LAST_T=7, free run for 20 cycles -> sc follows 0..7,0..7,0..3; wrap pulses twice.
REQ-037 halt at sc=5, hold 3 cycles, then start -> sc stays 5 for 3 cycles, then resumes 6,7,...; run=0 throughout HALTED.
REQ-038 clr and ld (ld_val=9) in the same cycle while in RUN at sc=12 -> sc=0 next edge, wrap=0, state stays RUN.
REQ-039 LAST_T=7, ld with ld_val=10 -> sc unchanged, ld_err=1 for one cycle; then ld with ld_val=3 -> sc=3, ld_err=0.
REQ-040 reset_n low for 1 ns, asynchronous to clock, at sc=9 -> sc=0 and run=0 without waiting for an edge; start held 0 -> sc stays 0.
